// File: rtl/out_port_fifo_pkg.sv
// Shared CPU definitions used by the buffered output port and by the control-unit
// decode that raises OutPortIn.
package out_port_fifo_pkg;

  localparam int DATA_W_DEF = 32;

  localparam int        OPC_W   = 5;
  localparam logic [4:0] OPC_OUT = 5'b01011;

  function automatic logic is_out_op(input logic [OPC_W-1:0] opc);
    return opc == OPC_OUT;
  endfunction

endpackage

// File: rtl/out_port_fifo_core.sv
// Generic synchronous FIFO storage: memory, wrapping pointers and occupancy count.
// The caller gates i_push/i_pop; the core only tracks state.
module out_port_fifo_core #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [CNT_W-1:0]  r_count;

  // Storage carries no reset; only entries below the count are ever observed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/out_port_fifo.sv
// Buffered CPU output port: OutPortIn strobes push bus words into a FIFO that drains
// to an external device over valid/ready; the last delivered word is held when empty.
module out_port_fifo
  import out_port_fifo_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              OutPortIn,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] port_data,
  output logic              port_valid,
  input  logic              port_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [DATA_W-1:0] w_rdata;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] r_last;
  logic              r_ovf;

  // full/empty are registered state, so neither handshake side loops combinationally.
  assign w_pop  = !w_empty && port_ready;
  assign w_push = OutPortIn && (!w_full || w_pop);
  assign w_drop = OutPortIn && w_full && !w_pop;

  out_port_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (bus_in),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Last-value latch keeps the old single-register port behaviour once drained.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= w_rdata;
    end
  end

  // A dropped write outranks a same-cycle clear so the loss is never hidden.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign port_valid = !w_empty;
  assign port_data  = w_empty ? r_last : w_rdata;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = w_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: a reference queue models contents, last value
// and overflow; every output is compared each cycle.
module tb_out_port_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              clr;
  logic              OutPortIn;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] port_data;
  logic              port_valid;
  logic              port_ready;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              ovf_clr;

  out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clr        (clr),
    .OutPortIn  (OutPortIn),
    .bus_in     (bus_in),
    .port_data  (port_data),
    .port_valid (port_valid),
    .port_ready (port_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_chk  = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] m_last;
  logic              m_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(sb_q.size()));
    chk({tag, ".full"}, 64'(full), 64'(sb_q.size() == DEPTH));
    chk({tag, ".empty"}, 64'(empty), 64'(sb_q.size() == 0));
    chk({tag, ".valid"}, 64'(port_valid), 64'(sb_q.size() != 0));
    chk({tag, ".data"}, 64'(port_data), 64'((sb_q.size() != 0) ? sb_q[0] : m_last));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  // One clock: drive at +1 after the edge, check pre-edge outputs, then post-edge state.
  task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rdy,
                      input logic oc, input string tag);
    logic              e_pop;
    logic              e_push;
    logic              hold;
    logic [DATA_W-1:0] held;
    OutPortIn  = wr;
    bus_in     = d;
    port_ready = rdy;
    ovf_clr    = oc;
    #1;
    e_pop  = (sb_q.size() != 0) && rdy;
    e_push = wr && ((sb_q.size() < DEPTH) || e_pop);
    hold   = port_valid && !rdy;
    held   = port_data;
    chk({tag, ".pre_valid"}, 64'(port_valid), 64'(sb_q.size() != 0));
    if (e_pop) begin
      m_last = sb_q.pop_front();
      chk({tag, ".popped"}, 64'(port_data), 64'(m_last));
    end else if (sb_q.size() == 0) begin
      chk({tag, ".nobypass"}, 64'(port_data), 64'(m_last));
    end
    if (e_push) sb_q.push_back(d);
    if (wr && !e_push) m_ovf = 1'b1;
    else if (oc)       m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk_state(tag);
    if (hold && port_valid) chk({tag, ".stable"}, 64'(port_data), 64'(held));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    clr = 1'b0; OutPortIn = 1'b0; bus_in = '0; port_ready = 1'b0; ovf_clr = 1'b0;
    m_last = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    clr = 1'b1;
    @(posedge clk);
    #1;

    // Single write with ready high, then pop leaving the latched word.
    step(1'b1, 32'hFFFE93C5, 1'b1, 1'b0, "single_wr");
    chk("single_vis", 64'(port_data), 64'h0000_0000_FFFE_93C5);
    step(1'b0, '0, 1'b1, 1'b0, "single_pop");
    chk("single_latch", 64'(port_data), 64'h0000_0000_FFFE_93C5);
    chk("single_empty", 64'(empty), 64'd1);

    // Fill with ready low, fifth write dropped.
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0, "fill");
    chk("fill_full", 64'(full), 64'd1);
    step(1'b1, 32'd5, 1'b0, 1'b0, "drop");
    chk("drop_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
    chk("drain_latch", 64'(port_data), 64'd4);

    // Overflow clear, then clear coincident with a dropped write.
    step(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf_cleared", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(32'h10 + i), 1'b0, 1'b0, "refill");
    step(1'b1, 32'hDEAD, 1'b0, 1'b1, "drop_and_clr");
    chk("set_wins", 64'(overflow), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1, "ovf_clr2");

    // Full with simultaneous push and pop.
    step(1'b1, 32'd9, 1'b1, 1'b0, "full_pushpop");
    chk("fpp_count", 64'(count), 64'd4);
    chk("fpp_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, "fpp_drain");
    chk("fpp_last9", 64'(port_data), 64'd9);

    // Random backpressure over 50 accepted writes.
    sent = 0;
    while (sent < 50) begin
      logic rdy;
      logic wr;
      rdy = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 3) != 0) && ((sb_q.size() < DEPTH) || (rdy && sb_q.size() != 0));
      step(wr, $urandom, rdy, 1'b0, "bp");
      if (wr) sent++;
    end
    while (sb_q.size() != 0) step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0, "bp_drain");
    chk("bp_ovf", 64'(overflow), 64'd0);

    // Asynchronous reset mid-stream with two entries queued.
    step(1'b1, 32'hA1, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 32'hA2, 1'b0, 1'b0, "pre_rst");
    OutPortIn = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    sb_q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    chk_state("async_rst");
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h55, 1'b1, 1'b0, "post_rst");
    step(1'b0, '0, 1'b1, 1'b0, "post_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
